// File: rtl/dram_axi_slave.sv
// AXI4-Lite-style record memory: independent single-outstanding read (AR/R) and write (AW/W/B) engines.
// Read data valid RD_LAT+2 cycles after the AR handshake cycle; W_READY after WR_LAT+2; responses held until ready.
module dram_axi_slave #(
  parameter logic [16:0] BASE_ADDR = 17'h10000,
  parameter int          DEPTH     = 256,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY,
  input  logic        ld_en,
  input  logic [7:0]  ld_idx,
  input  logic [63:0] ld_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_BRESP} wr_state_t;

  function automatic logic addr_legal(input logic [16:0] a);
    logic [16:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (a[2:0] == 3'b000) && (32'(off >> 3) < DEPTH);
  endfunction

  function automatic logic [IW-1:0] addr_idx(input logic [16:0] a);
    logic [16:0] off;
    off = a - BASE_ADDR;
    return IW'(off >> 3);
  endfunction

  logic [63:0] mem [DEPTH];

  rd_state_t   rd_state_q, rd_state_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [16:0] rd_addr_q;
  logic [63:0] r_data_q;
  logic [1:0]  r_resp_q;
  logic        rd_capture, ar_rdy, r_vld;

  wr_state_t   wr_state_q, wr_state_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic [16:0] wr_addr_q;
  logic [1:0]  b_resp_q;
  logic        w_commit, aw_rdy, w_rdy, b_vld;

  logic          rd_legal, wr_legal, ld_ok, ld_block;
  logic [IW-1:0] rd_idx, wr_idx, ld_idx_m;

  assign rd_legal = addr_legal(rd_addr_q);
  assign rd_idx   = addr_idx(rd_addr_q);
  assign wr_legal = addr_legal(wr_addr_q);
  assign wr_idx   = addr_idx(wr_addr_q);
  assign ld_idx_m = IW'(ld_idx);
  assign ld_ok    = 32'(ld_idx) < DEPTH;
  assign ld_block = w_commit && wr_legal && (wr_idx == ld_idx_m);

  // Readies are forced low while reset is asserted, not just after the next edge.
  assign AR_READY = rst_n & ar_rdy;
  assign R_VALID  = rst_n & r_vld;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign AW_READY = rst_n & aw_rdy;
  assign W_READY  = rst_n & w_rdy;
  assign B_VALID  = rst_n & b_vld;
  assign B_RESP   = b_resp_q;

  // ---------------- read engine ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= 4'd0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_capture = 1'b0;
    ar_rdy     = 1'b0;
    r_vld      = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        ar_rdy = 1'b1;
        if (AR_VALID) begin
          rd_state_d = RD_WAIT;
          rd_cnt_d   = 4'(RD_LAT);
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          rd_capture = 1'b1;
          rd_state_d = RD_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        r_vld = 1'b1;
        if (R_READY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= 17'd0;
      r_data_q  <= 64'd0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      if (rd_state_q == RD_IDLE && AR_VALID) rd_addr_q <= AR_ADDR;
      if (rd_capture) begin
        // Reads the pre-edge array, so a same-cycle W commit is not visible here.
        r_data_q <= rd_legal ? mem[rd_idx] : 64'd0;
        r_resp_q <= rd_legal ? RESP_OKAY : RESP_SLVERR;
      end else if (r_vld && R_READY) begin
        r_data_q <= 64'd0;
        r_resp_q <= RESP_OKAY;
      end
    end
  end

  // ---------------- write engine ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      wr_cnt_q   <= 4'd0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    w_commit   = 1'b0;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    b_vld      = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        aw_rdy = 1'b1;
        if (AW_VALID) begin
          wr_state_d = WR_ADDR;
          wr_cnt_d   = 4'(WR_LAT);
        end
      end
      WR_ADDR: begin
        if (wr_cnt_q == 4'd0) wr_state_d = WR_DATA;
        else                  wr_cnt_d   = wr_cnt_q - 4'd1;
      end
      WR_DATA: begin
        w_rdy = 1'b1;
        if (W_VALID) begin
          w_commit   = 1'b1;
          wr_state_d = WR_BRESP;
        end
      end
      WR_BRESP: begin
        b_vld = 1'b1;
        if (B_READY) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= 17'd0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      if (wr_state_q == WR_IDLE && AW_VALID) wr_addr_q <= AW_ADDR;
      if (w_commit)                b_resp_q <= wr_legal ? RESP_OKAY : RESP_SLVERR;
      else if (b_vld && B_READY)   b_resp_q <= RESP_OKAY;
    end
  end

  // Memory is never reset; w_commit is already inactive while reset holds the FSM idle.
  always_ff @(posedge clk) begin
    if (w_commit && wr_legal) mem[wr_idx] <= W_DATA;
    if (ld_en && ld_ok && !ld_block) mem[ld_idx_m] <= ld_data;
  end

endmodule

// File: doc/dram_axi_slave.md
Name: dram_axi_slave

Overview:
- AXI4-Lite-style memory responder that serves the single-outstanding read/write transactions issued by the Program block: AR/R channels for reads, AW/W/B channels for writes.
- Holds DEPTH 64-bit data records at byte addresses BASE_ADDR + 8*n.
- Read and write engines run independently and may be active at the same time.
- A backdoor load port lets the bench preload records.

Parameters:
- BASE_ADDR, 17'h10000, byte address of record 0
- DEPTH, 256, number of 64-bit records
- RD_LAT, 2, idle cycles between AR handshake and R_VALID rise (0..15)
- WR_LAT, 1, idle cycles between AW handshake and W_READY rise (0..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- AR_VALID  in  1  read address valid
- AR_ADDR  in  17  read byte address
- AR_READY  out  1  read address ready
- R_VALID  out  1  read data valid
- R_DATA  out  64  read data
- R_RESP  out  2  read response: 00 OKAY, 10 SLVERR
- R_READY  in  1  read data ready
- AW_VALID  in  1  write address valid
- AW_ADDR  in  17  write byte address
- AW_READY  out  1  write address ready
- W_VALID  in  1  write data valid
- W_DATA  in  64  write data
- W_READY  out  1  write data ready
- B_VALID  out  1  write response valid
- B_RESP  out  2  write response: 00 OKAY, 10 SLVERR
- B_READY  in  1  write response ready
- ld_en  in  1  backdoor write enable
- ld_idx  in  8  backdoor record index
- ld_data  in  64  backdoor record data

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous, active-low.
  - All ready/valid outputs are 0, R_DATA = 0, R_RESP = B_RESP = 00.
  - Both FSMs go to IDLE and latency counters clear.
  - Memory contents are not reset.
  - Reset mid-transaction abandons it; no memory write occurs unless the W handshake completed before reset.
- Address decode:
  - idx = (ADDR - BASE_ADDR) >> 3.
  - An address is legal iff ADDR >= BASE_ADDR, ADDR[2:0] = 0 and idx < DEPTH.
  - Illegal address gives response 10. Reads return R_DATA = 0; writes leave memory unchanged.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: AR_READY = 1 (combinational from state). When AR_VALID & AR_READY, latch the address and go to R_WAIT with cnt = RD_LAT.
  - R_WAIT: decrement cnt each cycle. When cnt = 0, capture mem[idx] (or 0) into R_DATA, set R_RESP, go to R_RESP.
  - R_RESP: R_VALID = 1. R_DATA and R_RESP are held stable until R_READY; on R_VALID & R_READY, return to R_IDLE and clear R_DATA.
  - With RD_LAT = 0, R_WAIT lasts exactly one cycle. The minimum handshake-to-R_VALID delay is therefore 2 cycles, and RD_LAT + 2 in general.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_BRESP:
  - W_IDLE: AW_READY = 1. On AW handshake, latch the address and go to W_ADDR with cnt = WR_LAT.
  - W_ADDR: count down; at 0 go to W_DATA.
  - W_DATA: W_READY = 1. On W_VALID & W_READY, write W_DATA to mem[idx] if legal (visible from the next cycle), set B_RESP, go to W_BRESP.
  - W_BRESP: B_VALID = 1 until B_READY, then go to W_IDLE.
- Ordering and concurrency:
  - W_VALID seen before W_DATA is not accepted; the master must hold it.
  - AR and AW handshakes in the same cycle are both accepted.
  - Read capture and W commit to the same idx in the same cycle: the read returns the old value.
  - ld_en has the lowest priority. It is ignored in the cycle a W commit targets the same index; otherwise it writes mem[ld_idx] immediately. ld_idx >= DEPTH is ignored.
- Protocol checks:
  - An AR_VALID or AW_VALID that drops before its handshake is simply not accepted; no error is raised.
  - R_VALID and B_VALID never drop without their handshake.

Test Plan:
- Basic read: ld mem[5] = 64'h0123_4567_89AB_CDEF; AR_ADDR = 17'h10028 -> R_VALID rises 4 cycles after the AR handshake (RD_LAT = 2), R_DATA = 64'h0123_4567_89AB_CDEF, R_RESP = 00.
- Backpressure: hold R_READY = 0 for 5 cycles -> R_VALID and R_DATA stay constant; a new AR_VALID is not accepted (AR_READY = 0) until after the R handshake.
- Program-style update: AR and AW both to 17'h10010 in the same cycle, read completes, W_DATA = 64'hFFF0_0A05_0123_4019 -> B_VALID with B_RESP = 00; a follow-up read of idx 2 returns the new data.
- Illegal addresses: AR_ADDR = 17'h0FFF8, 17'h10004, and 17'h10800 (idx 256) -> R_RESP = 10, R_DATA = 0; a write to 17'h10004 -> B_RESP = 10 and no memory changes.
- Same-cycle hazard: read capture and W commit to idx 7 coincide -> old value returned; the next read returns the new value.
- Reset mid-flight: assert rst_n = 0 during R_WAIT and during W_DATA -> all outputs are 0 asynchronously; after release, AR_READY = AW_READY = 1 and memory is unchanged.
